// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the PC fetch stage: FSM state encoding and
// field widths used by the fetch unit and its next-PC selector.
package mips_fetch_pkg;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Default width of the program counter and all address arithmetic.
  localparam int unsigned PC_WIDTH_DEFAULT = 32;

  // Instruction field widths feeding the next-PC logic.
  localparam int unsigned BRANCH_OFF_W = 16;
  localparam int unsigned JUMP_TGT_W   = 26;

endpackage : mips_fetch_pkg

// File: rtl/next_pc_sel.sv
// Combinational next-PC selector. Priority is stall > jump > branch >
// sequential. Addresses are word indices, so the sequential step is +1
// and branch offsets are applied in instructions relative to PC+1.
module next_pc_sel
  import mips_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT
) (
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic                    stall,
  input  logic                    jump,
  input  logic                    branch_taken,
  input  logic [BRANCH_OFF_W-1:0] branch_offset,
  input  logic [JUMP_TGT_W-1:0]   jump_target,
  output logic [PC_WIDTH-1:0]     next_pc,
  output logic                    advance,
  output logic                    redirect
);

  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] offset_ext;
  logic [PC_WIDTH-1:0] branch_pc;
  logic [PC_WIDTH-1:0] jump_pc;

  // Sequential successor; wraps modulo 2^PC_WIDTH.
  assign pc_plus1 = pc + PC_WIDTH'(1);

  // Sign-extend the branch offset up to the PC width (or truncate it
  // when the PC is narrower than the offset field).
  generate
    if (PC_WIDTH > BRANCH_OFF_W) begin : g_off_ext
      assign offset_ext = {{(PC_WIDTH - BRANCH_OFF_W){branch_offset[BRANCH_OFF_W-1]}},
                           branch_offset};
    end else begin : g_off_trunc
      assign offset_ext = branch_offset[PC_WIDTH-1:0];
    end
  endgenerate

  // Branch target is relative to PC+1; overflow simply wraps.
  assign branch_pc = pc_plus1 + offset_ext;

  // Jump keeps the upper bits of PC+1 and replaces the low field with
  // the jump target, MIPS-style region addressing.
  generate
    if (PC_WIDTH > JUMP_TGT_W) begin : g_jump_region
      assign jump_pc = {pc_plus1[PC_WIDTH-1:JUMP_TGT_W], jump_target};
    end else begin : g_jump_trunc
      assign jump_pc = jump_target[PC_WIDTH-1:0];
    end
  endgenerate

  // Priority mux: a stall freezes the PC, and jump beats branch.
  always_comb begin
    next_pc  = pc_plus1;
    advance  = 1'b1;
    redirect = 1'b0;
    if (stall) begin
      next_pc = pc;
      advance = 1'b0;
    end else if (jump) begin
      next_pc  = jump_pc;
      redirect = 1'b1;
    end else if (branch_taken) begin
      next_pc  = branch_pc;
      redirect = 1'b1;
    end
  end

endmodule : next_pc_sel

// File: rtl/pc_fetch_unit.sv
// Program-counter stage feeding instruction memory. Owns the PC register,
// the fetch counter and the IDLE/RUN/HALT sequencer. Every output is a
// flop, so a redirect presented in cycle N is visible in cycle N+1.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEFAULT,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned LAST_ADDR = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [BRANCH_OFF_W-1:0] branch_offset,
  input  logic                    jump,
  input  logic [JUMP_TGT_W-1:0]   jump_target,
  output logic [PC_WIDTH-1:0]     program_counter,
  output logic                    pc_valid,
  output logic                    halted,
  output logic [31:0]             fetch_count
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V  = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] LAST_ADDR_V = PC_WIDTH'(LAST_ADDR);

  fetch_state_e        state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [31:0]         count_reg, count_next;
  logic                pc_valid_reg, pc_valid_next;
  logic                halted_reg, halted_next;

  logic [PC_WIDTH-1:0] sel_next_pc;
  logic                sel_advance;
  logic                sel_redirect;

  next_pc_sel #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc_sel (
    .pc            (pc_reg),
    .stall         (stall),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .next_pc       (sel_next_pc),
    .advance       (sel_advance),
    .redirect      (sel_redirect)
  );

  // Next-state, next-PC and counter decisions for the fetch sequencer.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        // Redirect and stall inputs are meaningless before fetch starts.
        if (start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sel_advance) begin
          // The final instruction is still a fetch, so it is counted.
          count_next = count_reg + 32'd1;
          if (!sel_redirect && (pc_reg == LAST_ADDR_V)) begin
            state_next = ST_HALT;
          end else begin
            pc_next = sel_next_pc;
          end
        end
      end
      ST_HALT: begin
        // Frozen until reset.
      end
      default: begin
        state_next = ST_IDLE;
        pc_next    = RESET_PC_V;
      end
    endcase
    // Status flags are registered copies of the state being entered.
    pc_valid_next = (state_next == ST_RUN);
    halted_next   = (state_next == ST_HALT);
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC_V;
      count_reg    <= 32'd0;
      pc_valid_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      count_reg    <= count_next;
      pc_valid_reg <= pc_valid_next;
      halted_reg   <= halted_next;
    end
  end

  assign program_counter = pc_reg;
  assign pc_valid        = pc_valid_reg;
  assign halted          = halted_reg;
  assign fetch_count     = count_reg;

  // A halted unit never presents a fetchable address.
  a_valid_halt_exclusive : assert property (@(posedge clk) !(pc_valid_reg && halted_reg));

  // A stall in RUN must leave the PC untouched on the next cycle.
  a_stall_holds_pc : assert property (@(posedge clk)
    (!reset && state_reg == ST_RUN && stall) |=> (pc_reg == $past(pc_reg)));

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios from the test
// plan followed by randomized traffic compared against a behavioural model.
module tb_pc_fetch_unit;

  localparam int unsigned LAST = 4;
  localparam int unsigned RPC  = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic [31:0] program_counter;
  logic        pc_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
  int          m_mode = 0;
  logic [31:0] m_pc = 32'(RPC);
  logic [31:0] m_cnt = 32'd0;

  pc_fetch_unit #(
    .PC_WIDTH  (32),
    .RESET_PC  (RPC),
    .LAST_ADDR (LAST)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .jump_target     (jump_target),
    .program_counter (program_counter),
    .pc_valid        (pc_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  // Apply the spec rules to the inputs currently being driven.
  task automatic model_step();
    logic [31:0] seq;
    if (reset) begin
      m_mode = 0;
      m_pc   = 32'(RPC);
      m_cnt  = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1 && !stall) begin
      m_cnt = m_cnt + 1;
      seq   = m_pc + 1;
      if (jump)              m_pc = (seq & 32'hFC00_0000) | 32'(jump_target);
      else if (branch_taken) m_pc = 32'(longint'(seq) + longint'($signed(branch_offset)));
      else if (m_pc == LAST) m_mode = 2;
      else                   m_pc = seq;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 0; start = 0; stall = 0; branch_taken = 0; jump = 0;
    branch_offset = 16'h0; jump_target = 26'h0;
  endtask

  // Reset, start, then n plain RUN cycles: PC ends at RPC+n.
  task automatic run_to(input int n);
    quiet(); reset = 1; tick(); reset = 0;
    start = 1; tick(); start = 0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    quiet(); reset = 1; tick(); tick(); reset = 0;
    checks += 4;
    if (program_counter !== 32'(RPC)) begin errors++; $display("FAIL reset_pc: got %0h expected %0h", program_counter, RPC); end
    if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    $display("test_reset done");
  endtask

  task automatic test_sequential_halt();
    run_to(0);
    for (int i = 0; i <= int'(LAST); i++) begin
      checks += 3;
      if (program_counter !== 32'(i)) begin errors++; $display("FAIL seq_pc[%0d]: got %0h expected %0h", i, program_counter, i); end
      if (pc_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, pc_valid); end
      if (fetch_count !== 32'(i)) begin errors++; $display("FAIL seq_count[%0d]: got %0d expected %0d", i, fetch_count, i); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
      if (pc_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b expected 0", pc_valid); end
      if (program_counter !== 32'(LAST)) begin errors++; $display("FAIL halt_pc: got %0h expected %0h", program_counter, LAST); end
      if (fetch_count !== 32'(LAST + 1)) begin errors++; $display("FAIL halt_count: got %0d expected %0d", fetch_count, LAST + 1); end
      start = 1; jump = 1; jump_target = 26'h7; tick(); quiet();
    end
    $display("test_sequential_halt done");
  endtask

  task automatic test_branch();
    run_to(2);
    branch_taken = 1; branch_offset = 16'hFFFE; tick();
    checks += 1;
    if (program_counter !== 32'd1) begin errors++; $display("FAIL branch_back: got %0h expected 1", program_counter); end
    branch_offset = 16'h0003; tick(); quiet();
    checks += 2;
    if (program_counter !== 32'd5) begin errors++; $display("FAIL branch_fwd: got %0h expected 5", program_counter); end
    if (fetch_count !== 32'd4) begin errors++; $display("FAIL branch_count: got %0d expected 4", fetch_count); end
    $display("test_branch done");
  endtask

  task automatic test_jump_priority();
    run_to(3);
    jump = 1; jump_target = 26'h000000A; branch_taken = 1; branch_offset = 16'h0005; tick(); quiet();
    checks += 2;
    if (program_counter !== 32'd10) begin errors++; $display("FAIL jump_prio: got %0h expected a", program_counter); end
    if (pc_valid !== 1'b1) begin errors++; $display("FAIL jump_valid: got %b expected 1", pc_valid); end
    $display("test_jump_priority done");
  endtask

  task automatic test_stall();
    run_to(2);
    for (int i = 0; i < 3; i++) begin
      stall = 1; branch_taken = 1; branch_offset = 16'h0007; tick();
      checks += 2;
      if (program_counter !== 32'd2) begin errors++; $display("FAIL stall_pc[%0d]: got %0h expected 2", i, program_counter); end
      if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected 2", i, fetch_count); end
    end
    quiet(); tick();
    checks += 2;
    if (program_counter !== 32'd3) begin errors++; $display("FAIL post_stall_pc: got %0h expected 3", program_counter); end
    if (fetch_count !== 32'd3) begin errors++; $display("FAIL post_stall_count: got %0d expected 3", fetch_count); end
    $display("test_stall done");
  endtask

  task automatic test_branch_at_last();
    run_to(LAST);
    branch_taken = 1; branch_offset = 16'hFFFD; tick(); quiet();
    checks += 2;
    if (program_counter !== 32'(LAST - 2)) begin errors++; $display("FAIL last_branch_pc: got %0h expected %0h", program_counter, LAST - 2); end
    if (halted !== 1'b0) begin errors++; $display("FAIL last_branch_halt: got %b expected 0", halted); end
    repeat (3) tick();
    checks += 1;
    if (halted !== 1'b1) begin errors++; $display("FAIL reach_halt: got %b expected 1", halted); end
    reset = 1; tick(); reset = 0;
    checks += 4;
    if (program_counter !== 32'(RPC)) begin errors++; $display("FAIL halt_reset_pc: got %0h expected %0h", program_counter, RPC); end
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset_halted: got %b expected 0", halted); end
    if (pc_valid !== 1'b0) begin errors++; $display("FAIL halt_reset_valid: got %b expected 0", pc_valid); end
    if (fetch_count !== 32'd0) begin errors++; $display("FAIL halt_reset_count: got %0d expected 0", fetch_count); end
    $display("test_branch_at_last done");
  endtask

  task automatic test_idle_ignore();
    quiet(); reset = 1; tick(); reset = 0;
    jump = 1; jump_target = 26'h15; tick();
    jump = 0; branch_taken = 1; branch_offset = 16'h0009; tick();
    stall = 1; tick(); quiet();
    checks += 3;
    if (program_counter !== 32'(RPC)) begin errors++; $display("FAIL idle_pc: got %0h expected %0h", program_counter, RPC); end
    if (pc_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", pc_valid); end
    if (fetch_count !== 32'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", fetch_count); end
    $display("test_idle_ignore done");
  endtask

  task automatic test_random();
    int bad;
    quiet(); reset = 1; tick(); reset = 0;
    for (int i = 0; i < 800; i++) begin
      reset         = ($urandom_range(63) == 0);
      start         = ($urandom_range(5) == 0);
      stall         = ($urandom_range(3) == 0);
      jump          = ($urandom_range(9) == 0);
      branch_taken  = ($urandom_range(6) == 0);
      jump_target   = 26'($urandom_range(6));
      branch_offset = 16'($signed($urandom_range(8)) - 5);
      tick();
      bad = 0;
      checks += 4;
      if (program_counter !== m_pc) begin errors++; bad++; $display("FAIL rand_pc[%0d]: got %0h expected %0h", i, program_counter, m_pc); end
      if (pc_valid !== (m_mode == 1)) begin errors++; bad++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, pc_valid, m_mode == 1); end
      if (halted !== (m_mode == 2)) begin errors++; bad++; $display("FAIL rand_halted[%0d]: got %b expected %b", i, halted, m_mode == 2); end
      if (fetch_count !== m_cnt) begin errors++; bad++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, fetch_count, m_cnt); end
      if (bad != 0) begin
        // Resynchronise so one fault does not flood the log.
        quiet(); reset = 1; tick(); reset = 0;
      end
    end
    quiet();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_sequential_halt();
    test_branch();
    test_jump_priority();
    test_stall();
    test_branch_at_last();
    test_idle_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pc_fetch_unit
